// File: rtl/countdown_pkg.sv
// Shared constants and helpers for the cascaded BCD countdown timer.
package countdown_pkg;

   localparam int DIGIT_W = 4;

   // mm:ss layout in the low 16 bits (digit0 /10, digit1 /6, digit2 /10, digit3 /10).
   localparam logic [31:0] DEF_MOD_VECTOR = 32'hA6A6_AA6A;

   function automatic logic mod_legal(input logic [DIGIT_W-1:0] m);
      return (m >= 4'd2) && (m <= 4'd10);
   endfunction

endpackage

// File: rtl/counter_modn.sv
// One modulo-N BCD digit: loadable, decrements on borrow_i, wraps 0 -> N-1.
module counter_modn
   import countdown_pkg::*;
(
   input  logic               clock,
   input  logic               clearn,
   input  logic [DIGIT_W-1:0] modulus_i,
   input  logic [DIGIT_W-1:0] load_val_i,
   input  logic               load_i,
   input  logic               borrow_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               borrow_o,
   output logic               is_zero_o
);

   logic [DIGIT_W-1:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (load_i)
         digit_d = load_val_i;
      else if (borrow_i)
         digit_d = (digit_q == '0) ? (modulus_i - 4'd1) : (digit_q - 4'd1);
   end

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) digit_q <= '0;
      else         digit_q <= digit_d;
   end

   assign digit_o   = digit_q;
   assign is_zero_o = (digit_q == '0);
   assign borrow_o  = borrow_i && (digit_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Cascaded BCD countdown with load clamping, hold-at-zero and load_error pulse.
// Optional AUTO_RELOAD_EN: reload the last loaded value instead of holding at zero.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int                          NUM_DIGITS = 4,
   parameter logic [DIGIT_W*NUM_DIGITS-1:0] MOD_VECTOR = DEF_MOD_VECTOR[DIGIT_W*NUM_DIGITS-1:0]
) (
   input  logic                          clock,
   input  logic                          clearn,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
   input  logic                          loadn,
   input  logic                          enable,
   output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
   output logic                          tc,
   output logic                          zero,
   output logic                          load_error
);

   localparam int W = DIGIT_W * NUM_DIGITS;

   logic [NUM_DIGITS-1:0] over, is_zero;
   logic [NUM_DIGITS:0]   borrow;
   logic [W-1:0]          clamp_val, reload_val, load_val;
   logic                  underflow, load_strobe;
   logic                  load_error_q, load_error_d;

   // The chain is fed unconditionally; a borrow out of the top digit means the
   // count was already zero, and is turned into a reload (of 0 or the shadow).
   assign borrow[0]   = loadn && enable;
   assign underflow   = borrow[NUM_DIGITS];
   assign load_strobe = !loadn || underflow;
   assign load_val    = loadn ? reload_val : clamp_val;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      localparam logic [DIGIT_W-1:0] MOD_RAW = MOD_VECTOR[DIGIT_W*g +: DIGIT_W];
      // An out-of-range modulus falls back to plain decimal.
      localparam logic [DIGIT_W-1:0] MOD_G   = mod_legal(MOD_RAW) ? MOD_RAW : 4'd10;

      assign over[g] = data[DIGIT_W*g +: DIGIT_W] >= MOD_G;
      assign clamp_val[DIGIT_W*g +: DIGIT_W] =
         over[g] ? (MOD_G - 4'd1) : data[DIGIT_W*g +: DIGIT_W];

      counter_modn u_digit (
         .clock      (clock),
         .clearn     (clearn),
         .modulus_i  (MOD_G),
         .load_val_i (load_val[DIGIT_W*g +: DIGIT_W]),
         .load_i     (load_strobe),
         .borrow_i   (borrow[g]),
         .digit_o    (digits[DIGIT_W*g +: DIGIT_W]),
         .borrow_o   (borrow[g+1]),
         .is_zero_o  (is_zero[g])
      );
   end

`ifdef AUTO_RELOAD_EN
   logic [W-1:0] shadow_q, shadow_d;

   assign shadow_d = loadn ? shadow_q : clamp_val;

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) shadow_q <= '0;
      else         shadow_q <= shadow_d;
   end

   assign reload_val = shadow_q;
`else
   assign reload_val = '0;
`endif

   // Loading together with enable is flagged as misuse, same as a clamped digit.
   assign load_error_d = !loadn && (enable || (|over));

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) load_error_q <= 1'b0;
      else         load_error_q <= load_error_d;
   end

   assign zero       = &is_zero;
   assign tc         = underflow && clearn;
   assign load_error = load_error_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (4 digits, mm:ss); tracks the count as a
// plain integer of seconds and checks the DUT every cycle against it.
module tb_countdown_timer;

   localparam int MODS [4] = '{10, 6, 10, 10};
`ifdef AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        clearn = 1'b1;
   logic [15:0] data = '0;
   logic        loadn = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] digits;
   logic        tc, zero, load_error;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   int m_val = 0;
   int m_shadow = 0;
   bit m_err = 1'b0;

   countdown_timer #(.NUM_DIGITS(4), .MOD_VECTOR(16'hAA6A)) dut (
      .clock(clock), .clearn(clearn), .data(data), .loadn(loadn), .enable(enable),
      .digits(digits), .tc(tc), .zero(zero), .load_error(load_error)
   );

   always #5 clock = ~clock;

   function automatic int load_value(input logic [15:0] d);
      int v = 0;
      int w = 1;
      for (int i = 0; i < 4; i++) begin
         int n = int'(d[4*i +: 4]);
         if (n >= MODS[i]) n = MODS[i] - 1;
         v += n * w;
         w *= MODS[i];
      end
      return v;
   endfunction

   function automatic bit any_over(input logic [15:0] d);
      bit b = 1'b0;
      for (int i = 0; i < 4; i++)
         if (int'(d[4*i +: 4]) >= MODS[i]) b = 1'b1;
      return b;
   endfunction

   function automatic logic [15:0] to_digits(input int v);
      logic [15:0] r = '0;
      int t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % MODS[i]);
         t = t / MODS[i];
      end
      return r;
   endfunction

   // Reference model: count in seconds, converted to display digits on compare.
   always @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         m_val <= 0; m_shadow <= 0; m_err <= 1'b0;
      end else if (!loadn) begin
         m_val    <= load_value(data);
         m_shadow <= load_value(data);
         m_err    <= enable || any_over(data);
      end else begin
         m_err <= 1'b0;
         if (enable) m_val <= (m_val > 0) ? m_val - 1 : (AUTO ? m_shadow : 0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (chk_on) begin
         chk("m.digits", 32'(digits), 32'(to_digits(m_val)));
         chk("m.zero", 32'(zero), 32'(m_val == 0));
         chk("m.tc", 32'(tc), 32'(clearn && (m_val == 0) && enable && loadn));
         chk("m.load_error", 32'(load_error), 32'(m_err));
      end
   end

   task automatic cyc(input logic l, input logic e, input logic [15:0] d);
      loadn = l; enable = e; data = d;
      @(negedge clock); #1;
   endtask

   initial begin
      #2 clearn = 1'b0;
      enable = 1'b1;
      @(negedge clock); #1;
      chk("rst.digits", 32'(digits), 32'h0000);
      chk("rst.zero", 32'(zero), 32'h1);
      chk("rst.tc", 32'(tc), 32'h0);
      chk("rst.load_error", 32'(load_error), 32'h0);
      clearn = 1'b1;
      enable = 1'b0;
      chk_on = 1'b1;

      // 01:00 countdown to zero, then hold (or reload)
      cyc(1'b0, 1'b0, 16'h0100);
      chk("ld0100", 32'(digits), 32'h0100);
      cyc(1'b1, 1'b1, 16'h0000);
      chk("dec0059", 32'(digits), 32'h0059);
      cyc(1'b1, 1'b1, 16'h0000);
      chk("dec0058", 32'(digits), 32'h0058);
      for (int i = 0; i < 58; i++) cyc(1'b1, 1'b1, 16'h0000);
      chk("end.digits", 32'(digits), 32'h0000);
      chk("end.tc", 32'(tc), 32'h1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 16'h0000);
      if (!AUTO) chk("hold.digits", 32'(digits), 32'h0000);

      // clamped load
      cyc(1'b0, 1'b0, 16'h007C);
      chk("clamp.digits", 32'(digits), 32'h0059);
      chk("clamp.err", 32'(load_error), 32'h1);
      cyc(1'b1, 1'b0, 16'h0000);
      chk("clamp.err_drop", 32'(load_error), 32'h0);
      cyc(1'b0, 1'b0, 16'hFFFF);
      chk("clampmax", 32'(digits), 32'h9959);

      // load and enable together
      cyc(1'b0, 1'b1, 16'h0030);
      chk("ldEn.digits", 32'(digits), 32'h0030);
      chk("ldEn.err", 32'(load_error), 32'h1);
      cyc(1'b1, 1'b0, 16'h0000);

      // async reset mid-count
      cyc(1'b0, 1'b0, 16'h0010);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'h0000);
      chk("pre_rst", 32'(digits), 32'h0007);
      #2 clearn = 1'b0;
      #1;
      chk("async.digits", 32'(digits), 32'h0000);
      chk("async.tc", 32'(tc), 32'h0);
      @(negedge clock); #1;
      cyc(1'b1, 1'b1, 16'h0000);
      clearn = 1'b1;
      cyc(1'b1, 1'b1, 16'h0000);
      cyc(1'b1, 1'b1, 16'h0000);
      chk("post_rst.digits", 32'(digits), 32'h0000);
      chk("post_rst.tc", 32'(tc), 32'h1);

      // gated enable
      cyc(1'b0, 1'b0, 16'h0005);
      cyc(1'b1, 1'b1, 16'h0000); chk("tog1", 32'(digits), 32'h0004);
      cyc(1'b1, 1'b0, 16'h0000); chk("tog2", 32'(digits), 32'h0004);
      cyc(1'b1, 1'b1, 16'h0000); chk("tog3", 32'(digits), 32'h0003);
      cyc(1'b1, 1'b0, 16'h0000); chk("tog4", 32'(digits), 32'h0003);

      // zero crossing: reload or hold
      cyc(1'b0, 1'b0, 16'h0002);
      cyc(1'b1, 1'b1, 16'h0000); chk("ar1", 32'(digits), 32'h0001);
      cyc(1'b1, 1'b1, 16'h0000); chk("ar0", 32'(digits), 32'h0000);
      chk("ar0.tc", 32'(tc), 32'h1);
      cyc(1'b1, 1'b1, 16'h0000); chk("ar_next", 32'(digits), AUTO ? 32'h0002 : 32'h0000);
      cyc(1'b1, 1'b1, 16'h0000); chk("ar_next2", 32'(digits), AUTO ? 32'h0001 : 32'h0000);
      cyc(1'b1, 1'b0, 16'h0000);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
